fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one sync_fifo write port between NREQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one owner at a time, with a burst cap per grant.
- It drives the FIFO wr_en and data_in, and throttles on fifo_full.
- It sits directly in front of sync_fifo. The read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width; matches the sync_fifo data_in width
BURST, 4, maximum words written per grant before re-arbitration (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  NREQ  per-requester word valid
req_data  input  NREQ*DW  requester i data at bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept
fifo_full  input  1  from sync_fifo
fifo_wr_en  output  1  to sync_fifo wr_en
fifo_data_in  output  DW  to sync_fifo data_in
grant  output  NREQ  one-hot current owner, registered; all-zero when idle
busy  output  1  high while in GRANT

Behaviour:
- State machine has two states, IDLE and GRANT. Registers are state, grant, last_owner and burst_cnt.
- Reset (rst=0, asynchronous, any time including mid-burst):
  - state=IDLE, grant=0, burst_cnt=0.
  - last_owner=NREQ-1, so the first pick is requester 0.
  - Hence req_ready=0, fifo_wr_en=0, fifo_data_in=0, busy=0.
- Arbitration pick:
  - Scan from last_owner+1 upward, wrapping modulo NREQ. The first requester with req_valid=1 wins.
  - The previous owner is considered last.
- IDLE:
  - If any req_valid is high, load grant with the pick, set last_owner=pick, burst_cnt=0, and go to GRANT next cycle.
  - This costs one cycle of grant latency.
  - Otherwise stay in IDLE.
- GRANT, combinational outputs:
  - req_ready[o] = grant[o] & ~fifo_full. All other ready bits are 0.
  - xfer = req_valid[o] & req_ready[o].
  - fifo_wr_en = xfer.
  - fifo_data_in = req_data of the owner when xfer=1, else 0.
  - There are zero cycles from handshake to FIFO write; sync_fifo captures on the same edge.
- GRANT, on xfer: burst_cnt increments.
- GRANT, release conditions:
  - Release (a): xfer with burst_cnt==BURST-1.
  - Release (b): req_valid[o]=0 for a cycle while fifo_full=0.
- GRANT, on release:
  - Re-arbitrate on the same edge using the current req_valid. The owner's bit counts only in the burst-cap case.
  - If a pick exists, load the new grant, update last_owner, and set burst_cnt=0, staying in GRANT with no dead cycle.
  - Otherwise go to IDLE with grant=0.
- GRANT, while fifo_full=1:
  - Hold the grant, keep ready low, and freeze burst_cnt.
  - Do not release even if the owner's valid drops. Release (b) is evaluated only while fifo_full=0.
- req_valid from non-owners is ignored until the next arbitration point; there is no preemption.
- A single active requester gets back-to-back bursts, with no dead cycle at the burst boundary.

Optional Feature:
Macro ARB_PRIO0_EN.
- Defined:
  - At every arbitration point, requester 0 wins if its req_valid is high. Otherwise the round-robin pick runs over 1..NREQ-1 only.
  - last_owner is updated only by grants to requesters 1..NREQ-1.
  - Requester 0 is still burst-capped and never preempts an in-progress burst.
- Undefined: pure round-robin over all NREQ requesters, as described above.

Test Plan:
1. Reset then single requester: req_valid=4'b0001, data 0..9 streamed.
   - grant=0001 one cycle after valid.
   - FIFO receives 0..9 in order.
   - fifo_wr_en pulses for 10 cycles, with no gap at word 4/5 or 8/9.
2. All four requesters valid continuously, BURST=4, each sending its own index:
   - Writes arrive as four words each, in owner order 0,1,2,3,0,1,...
   - grant transitions have no idle cycle between owners.
3. fifo_full: requester 1 owns grant, fifo_full asserted after 2 words for 5 cycles.
   - req_ready[1]=0 and fifo_wr_en=0 for those 5 cycles; grant stays 0010.
   - The remaining 2 words are written after full drops, then release.
4. Early release: requester 2 drops valid after 1 word while requester 3 is waiting.
   - grant moves 0100 to 1000 on the next edge.
   - Requester 3's first word is written the following cycle.
5. Asynchronous reset mid-burst: assert rst=0 between clock edges during a grant to requester 2.
   - grant, busy and fifo_wr_en go to 0 immediately.
   - After release from reset, the first grant goes to requester 0 when all are valid.
6. ARB_PRIO0_EN defined with req_valid=4'b1111:
   - Requester 0 is granted at every arbitration point.
   - With requester 0 invalid, 1,2,3 rotate.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NREQ valid/ready producers.
// Optional macro ARB_PRIO0_EN: requester 0 wins every arbitration point at which it is valid.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_data_in,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [LW-1:0]   last_owner, last_owner_nxt;
  logic [3:0]      burst_cnt, burst_cnt_nxt;
  logic            pick_vld;
  logic [LW-1:0]   pick_idx;
  logic            owner_valid;
  logic            xfer;
  logic            arb;

  // Arbitration pick: scan upward from last_owner+1; the previous owner comes last.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) begin
      pick_vld = 1'b1;
    end else begin
      // last_owner never holds 0 here, so rotation runs over 1..NREQ-1 only
      for (int unsigned off = 1; off < NREQ; off++) begin
        cand = 1 + ((32'(last_owner) + off - 1) % (NREQ - 1));
        if (!pick_vld && req_valid[LW'(cand)]) begin
          pick_vld = 1'b1;
          pick_idx = LW'(cand);
        end
      end
    end
`else
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(last_owner) + off) % NREQ;
      if (!pick_vld && req_valid[LW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = LW'(cand);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= LW'(NREQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    arb            = 1'b0;
    case (state)
      IDLE: arb = |req_valid;
      GRANT: begin
        // While full, the grant and count are frozen and a dropped valid is ignored.
        if (!fifo_full) begin
          if (xfer) begin
            if (burst_cnt == 4'(BURST - 1)) arb = 1'b1;
            else                            burst_cnt_nxt = burst_cnt + 4'd1;
          end else if (!owner_valid) begin
            arb = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb) begin
      burst_cnt_nxt = '0;
      if (pick_vld) begin
        state_nxt = GRANT;
        grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
`ifdef ARB_PRIO0_EN
        if (pick_idx != '0) last_owner_nxt = pick_idx;
`else
        last_owner_nxt = pick_idx;
`endif
      end else begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    if (state == GRANT) req_ready = grant & {NREQ{~fifo_full}};
    owner_valid = |(req_valid & grant);
    xfer        = |(req_valid & req_ready);
    fifo_wr_en  = xfer;
    busy        = (state == GRANT);
    if (xfer) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) fifo_data_in = fifo_data_in | req_data[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues feed requesters, expected FIFO writes are checked in order.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full = 1'b0;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data_in;
  logic [NREQ-1:0]    grant;
  logic               busy;

  logic [DW-1:0]      src_q [NREQ][$];
  exp_t               exp_q [$];
  logic [NREQ-1:0]    hs;
  int                 checks = 0;
  int                 failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant(grant), .busy(busy)
  );

  // Producers: handshake seen at negedge, word retired and next word presented just after posedge.
  always begin
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req_valid[i] = (src_q[i].size() > 0);
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  end

  // FIFO-side scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got grant=%b data=%h, want no write", grant, fifo_data_in);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (fifo_data_in !== e.data || grant !== e.gnt) begin
          failures++;
          $display("FAIL wr_data: got grant=%b data=%h, want grant=%b data=%h",
                   grant, fifo_data_in, e.gnt, e.data);
        end
      end
    end
  end

  task automatic feed(input int r, input int first, input int n);
    for (int k = 0; k < n; k++) src_q[r].push_back(DW'(r*16 + first + k));
  endtask

  task automatic expect_words(input int r, input int first, input int n);
    exp_t e;
    e.gnt    = '0;
    e.gnt[r] = 1'b1;
    for (int k = 0; k < n; k++) begin
      e.data = DW'(r*16 + first + k);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      @(negedge clk);
      if (grant === '0 && busy === 1'b0 && exp_q.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(8'hEE);
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got grant=%b busy=%b, want 0000/0", grant, busy);
    end
    checks++;
    if (req_ready !== '0 || fifo_wr_en !== 1'b0 || fifo_data_in !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b wr_en=%b data=%h, want 0", req_ready, fifo_wr_en, fifo_data_in);
    end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    feed(0, 0, 10);
    expect_words(0, 0, 10);
    @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_latency: got grant=%b busy=%b, want 0000/0", grant, busy);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got %b, want 0001", grant);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1) begin
        failures++;
        $display("FAIL single_stream word %0d: got wr_en=%b, want 1", k, fifo_wr_en);
      end
    end
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL single_end: got wr_en=%b, want 0", fifo_wr_en);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_drain: got grant=%b pending=%0d, want 0000/0", grant, exp_q.size());
    end
  endtask

`ifndef ARB_PRIO0_EN
  task automatic test_all_valid();
    bit ok;
    int gaps;
    do_reset();
    for (int r = 0; r < NREQ; r++) feed(r, 0, 8);
    for (int rd = 0; rd < 2; rd++)
      for (int r = 0; r < NREQ; r++) expect_words(r, rd*4, 4);
    wait_wr(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_start: got no write in 50 cycles, want write");
    end
    gaps = 0;
    for (int n = 1; n < 32; n++) begin
      @(negedge clk);
      if (fifo_wr_en !== 1'b1) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL rr_back_to_back: got %0d idle cycles, want 0", gaps);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_drain: got grant=%b pending=%0d, want 0000/0", grant, exp_q.size());
    end
  endtask
`endif

  task automatic test_full();
    bit ok;
    do_reset();
    feed(1, 0, 4);
    expect_words(1, 0, 4);
    wait_wr(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_start: got no write in 50 cycles, want write");
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (req_ready[1] !== 1'b0 || fifo_wr_en !== 1'b0 || grant !== 4'b0010) begin
        failures++;
        $display("FAIL full_hold cycle %0d: got ready=%b wr_en=%b grant=%b, want 0/0/0010",
                 n, req_ready[1], fifo_wr_en, grant);
      end
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || grant !== 4'b0010) begin
        failures++;
        $display("FAIL full_resume word %0d: got wr_en=%b grant=%b, want 1/0010", n + 2, fifo_wr_en, grant);
      end
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_drain: got grant=%b pending=%0d, want 0000/0", grant, exp_q.size());
    end
  endtask

  task automatic test_early_release();
    bit ok;
    do_reset();
    feed(2, 0, 1);
    feed(3, 0, 4);
    expect_words(2, 0, 1);
    expect_words(3, 0, 4);
    wait_wr(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL early_start: got no write in 50 cycles, want write");
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || fifo_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL early_drop: got grant=%b wr_en=%b, want 0100/0", grant, fifo_wr_en);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000 || fifo_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL early_handover: got grant=%b wr_en=%b, want 1000/1", grant, fifo_wr_en);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL early_drain: got grant=%b pending=%0d, want 0000/0", grant, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    feed(2, 0, 8);
    expect_words(2, 0, 8);
    wait_wr(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL areset_start: got no write in 50 cycles, want write");
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: got grant=%b busy=%b wr_en=%b, want 0000/0/0", grant, busy, fifo_wr_en);
    end
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    for (int r = 0; r < NREQ; r++) feed(r, 0, 2);
    for (int r = 0; r < NREQ; r++) expect_words(r, 0, 2);
    wait_wr(ok);
    checks++;
    if (!ok || grant !== 4'b0001) begin
      failures++;
      $display("FAIL areset_first_grant: got grant=%b write=%b, want 0001/1", grant, ok);
    end
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL areset_drain: got grant=%b pending=%0d, want 0000/0", grant, exp_q.size());
    end
  endtask

`ifdef ARB_PRIO0_EN
  task automatic test_prio0();
    bit ok;
    do_reset();
    for (int r = 0; r < NREQ; r++) feed(r, 0, 8);
    expect_words(0, 0, 8);
    for (int rd = 0; rd < 2; rd++)
      for (int r = 1; r < NREQ; r++) expect_words(r, rd*4, 4);
    wait_wr(ok);
    checks++;
    if (!ok || grant !== 4'b0001) begin
      failures++;
      $display("FAIL prio0_first: got grant=%b write=%b, want 0001/1", grant, ok);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL prio0_drain: got grant=%b pending=%0d, want 0000/0", grant, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
`ifndef ARB_PRIO0_EN
    test_all_valid();
`endif
    test_full();
    test_early_release();
    test_async_reset();
`ifdef ARB_PRIO0_EN
    test_prio0();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
